// File: rtl/irrigation_sequencer.sv
// ---------------------------------------------------------------------------
// irrigation_sequencer
//
// Multi-zone irrigation sequencer. Up to ZONES zone requests are served in
// round-robin order; each zone runs for its programmed number of minute
// ticks and drives the shared 2-bit valve code (00 off, 01 sprinkler,
// 10 drip). Hybrid zones switch from sprinkler to drip at SWITCH_MIN on the
// BCD minute clock. The alarm input freezes a running zone (HOLD) and blocks
// new starts.
//
// Optional feature macro: IRRIGATION_RAIN_LOCK_EN
//   When defined, a `rain` input is added. While rain is high no new zone is
//   started; a zone already running finishes normally.
// ---------------------------------------------------------------------------
module irrigation_sequencer #(
    parameter int ZONES      = 4,
    parameter int DUR_W      = 8,
    parameter int SWITCH_MIN = 30
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic [3:0]                 ddm,
    input  logic [3:0]                 udm,
    input  logic                       alarm,
`ifdef IRRIGATION_RAIN_LOCK_EN
    input  logic                       rain,
`endif
    input  logic [3*ZONES-1:0]         req,
    input  logic [DUR_W*ZONES-1:0]     dur,
    output logic [1:0]                 coded_irg,
    output logic [$clog2(ZONES)-1:0]   active_zone,
    output logic                       busy,
    output logic                       done
);

    localparam int         ZW          = $clog2(ZONES);
    localparam logic [5:0] SWITCH_MIN6 = 6'(SWITCH_MIN);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_RUN    = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    state_t            state_r;
    logic [DUR_W-1:0]  cnt_r;
    logic [2:0]        mode_r;
    logic [ZW-1:0]     last_r;

    logic [ZONES-1:0]  valid_s;
    logic              any_valid_s;
    logic              start_block_s;
    logic              pick_found_s;
    logic [ZW-1:0]     pick_zone_s;
    logic [2:0]        pick_mode_s;
    logic [DUR_W-1:0]  pick_dur_s;

    // A request field is usable only when exactly one mode bit is set.
    function automatic logic is_onehot3(input logic [2:0] field);
        logic result;
        case (field)
            3'b001:  result = 1'b1;
            3'b010:  result = 1'b1;
            3'b100:  result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    // Valve code for a latched mode at the given BCD minute. Any invalid BCD
    // digit counts as "late", so a hybrid zone falls back to drip.
    function automatic logic [1:0] mode_code(input logic [2:0] mode,
                                             input logic [3:0] tens,
                                             input logic [3:0] units);
        logic [5:0] minute;
        logic       late;
        logic [1:0] code;
        minute = ({2'b00, tens} << 3) + ({2'b00, tens} << 1) + {2'b00, units};
        late   = (tens > 4'd5) || (units > 4'd9) || (minute >= SWITCH_MIN6);
        case (mode)
            3'b100:  code = 2'b01;
            3'b010:  code = 2'b10;
            3'b001:  code = late ? 2'b10 : 2'b01;
            default: code = 2'b00;
        endcase
        return code;
    endfunction

    // Per-zone request qualification: one-hot mode and a nonzero duration.
    always_comb begin
        valid_s = {ZONES{1'b0}};
        for (int z = 0; z < ZONES; z++) begin
            valid_s[z] = is_onehot3(req[3*z +: 3]) &&
                         (dur[DUR_W*z +: DUR_W] != {DUR_W{1'b0}});
        end
        any_valid_s = |valid_s;
    end

    // Conditions that forbid starting a new zone.
    always_comb begin
`ifdef IRRIGATION_RAIN_LOCK_EN
        start_block_s = alarm | rain;
`else
        start_block_s = alarm;
`endif
    end

    // Round-robin search: first valid zone after the last one served.
    always_comb begin : pick_search
        logic [ZW-1:0] cand_zone;
        pick_found_s = 1'b0;
        pick_zone_s  = {ZW{1'b0}};
        pick_mode_s  = 3'b000;
        pick_dur_s   = {DUR_W{1'b0}};
        cand_zone    = {ZW{1'b0}};
        for (int i = 1; i <= ZONES; i++) begin
            cand_zone = ZW'((int'(last_r) + i) % ZONES);
            if (!pick_found_s && valid_s[cand_zone]) begin
                pick_found_s = 1'b1;
                pick_zone_s  = cand_zone;
                pick_mode_s  = req[3*int'(cand_zone) +: 3];
                pick_dur_s   = dur[DUR_W*int'(cand_zone) +: DUR_W];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Sequencer FSM with registered valve code, zone, busy and done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {DUR_W{1'b0}};
            mode_r      <= 3'b000;
            last_r      <= ZW'(ZONES - 1);
            coded_irg   <= 2'b00;
            active_zone <= {ZW{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    coded_irg <= 2'b00;
                    busy      <= 1'b0;
                    if (!start_block_s && any_valid_s) begin
                        state_r <= ST_SELECT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_SELECT: begin
                    if (!start_block_s && pick_found_s) begin
                        state_r     <= ST_RUN;
                        active_zone <= pick_zone_s;
                        cnt_r       <= pick_dur_s;
                        mode_r      <= pick_mode_s;
                        coded_irg   <= mode_code(pick_mode_s, ddm, udm);
                        busy        <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        coded_irg <= 2'b00;
                        busy      <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (alarm) begin
                        // Alarm beats a coincident tick: the count is frozen.
                        state_r   <= ST_HOLD;
                        coded_irg <= 2'b00;
                        busy      <= 1'b1;
                    end else if (!valid_s[active_zone]) begin
                        // Request withdrawn: end early without done.
                        state_r   <= ST_GAP;
                        last_r    <= active_zone;
                        coded_irg <= 2'b00;
                        busy      <= 1'b0;
                    end else if (tick) begin
                        cnt_r <= cnt_r - DUR_W'(1);
                        if (cnt_r == DUR_W'(1)) begin
                            state_r   <= ST_GAP;
                            last_r    <= active_zone;
                            done      <= 1'b1;
                            coded_irg <= 2'b00;
                            busy      <= 1'b0;
                        end else begin
                            state_r   <= ST_RUN;
                            coded_irg <= mode_code(mode_r, ddm, udm);
                            busy      <= 1'b1;
                        end
                    end else begin
                        state_r   <= ST_RUN;
                        coded_irg <= mode_code(mode_r, ddm, udm);
                        busy      <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    busy <= 1'b1;
                    if (alarm) begin
                        state_r   <= ST_HOLD;
                        coded_irg <= 2'b00;
                    end else begin
                        state_r   <= ST_RUN;
                        coded_irg <= mode_code(mode_r, ddm, udm);
                    end
                end

                ST_GAP: begin
                    // Single break-before-make cycle between valves.
                    coded_irg <= 2'b00;
                    busy      <= 1'b0;
                    if (alarm) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_SELECT;
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    coded_irg <= 2'b00;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// ---------------------------------------------------------------------------
// tb_irrigation_sequencer
//
// Self-checking bench: a behavioural model (zone queue walk, minute
// arithmetic, remaining-tick count) predicts the outputs every cycle, a
// compare process checks them on the falling edge, and directed scenarios
// pin hand-computed values. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_irrigation_sequencer;

    localparam int ZONES = 4;
    localparam int DUR_W = 8;
    localparam int SW    = 30;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   tick;
    logic [3:0]             ddm;
    logic [3:0]             udm;
    logic                   alarm;
    logic [3*ZONES-1:0]     req;
    logic [DUR_W*ZONES-1:0] dur;
    logic [1:0]             coded_irg;
    logic [1:0]             active_zone;
    logic                   busy;
    logic                   done;
`ifdef IRRIGATION_RAIN_LOCK_EN
    logic                   rain = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Model state
    typedef enum int {M_IDLE, M_PICK, M_ON, M_PAUSE, M_BREAK} mphase_t;
    mphase_t    ph;
    int         left_ticks;
    int         last_served;
    logic [2:0] run_mode;
    int         exp_code;
    int         exp_zone;
    int         exp_busy;
    int         exp_done;

    irrigation_sequencer #(.ZONES(ZONES), .DUR_W(DUR_W), .SWITCH_MIN(SW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .ddm         (ddm),
        .udm         (udm),
        .alarm       (alarm),
`ifdef IRRIGATION_RAIN_LOCK_EN
        .rain        (rain),
`endif
        .req         (req),
        .dur         (dur),
        .coded_irg   (coded_irg),
        .active_zone (active_zone),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit zone_ok(input int z);
        logic [2:0] f;
        int         d;
        f = req[3*z +: 3];
        d = int'(dur[DUR_W*z +: DUR_W]);
        return ($countones(f) == 1) && (d != 0);
    endfunction

    function automatic bit any_zone();
        bit r = 1'b0;
        for (int z = 0; z < ZONES; z++) r = r | zone_ok(z);
        return r;
    endfunction

    function automatic int valve_for(input logic [2:0] m);
        int minute;
        bit bad;
        bad    = (ddm > 4'd9) || (ddm > 4'd5) || (udm > 4'd9);
        minute = int'(ddm) * 10 + int'(udm);
        if (m == 3'b100) return 1;
        if (m == 3'b010) return 2;
        if (m == 3'b001) return (bad || minute >= SW) ? 2 : 1;
        return 0;
    endfunction

    task automatic model_reset();
        ph = M_IDLE; left_ticks = 0; last_served = ZONES - 1; run_mode = 3'b000;
        exp_code = 0; exp_zone = 0; exp_busy = 0; exp_done = 0;
    endtask

    task automatic model_step();
        int nz;
        exp_done = 0;
        case (ph)
            M_IDLE:  if (!alarm && any_zone()) ph = M_PICK;
            M_PICK: begin
                nz = -1;
                if (!alarm)
                    for (int i = 1; i <= ZONES; i++)
                        if (nz < 0 && zone_ok((last_served + i) % ZONES)) nz = (last_served + i) % ZONES;
                if (nz < 0) ph = M_IDLE;
                else begin
                    exp_zone   = nz;
                    left_ticks = int'(dur[DUR_W*nz +: DUR_W]);
                    run_mode   = req[3*nz +: 3];
                    ph         = M_ON;
                end
            end
            M_ON: begin
                if (alarm) ph = M_PAUSE;
                else if (!zone_ok(exp_zone)) begin last_served = exp_zone; ph = M_BREAK; end
                else if (tick) begin
                    left_ticks = left_ticks - 1;
                    if (left_ticks == 0) begin exp_done = 1; last_served = exp_zone; ph = M_BREAK; end
                end
            end
            M_PAUSE: if (!alarm) ph = M_ON;
            M_BREAK: ph = alarm ? M_IDLE : M_PICK;
            default: ph = M_IDLE;
        endcase
        exp_busy = (ph == M_ON || ph == M_PAUSE) ? 1 : 0;
        exp_code = (ph == M_ON) ? valve_for(run_mode) : 0;
    endtask

    // Model advances on the same edges the design sees.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("coded_irg", int'(coded_irg), exp_code);
            check("active_zone", int'(active_zone), exp_zone);
            check("busy", int'(busy), exp_busy);
            check("done", int'(done), exp_done);
        end
    end

    task automatic expect_out(input string tag, input int c, input int z, input int b, input int d);
        check({tag, ".code"}, int'(coded_irg), c);
        check({tag, ".zone"}, int'(active_zone), z);
        check({tag, ".busy"}, int'(busy), b);
        check({tag, ".done"}, int'(done), d);
    endtask

    task automatic cyc_expect(input string tag, input int c, input int z, input int b, input int d);
        @(negedge clk);
        expect_out(tag, c, z, b, d);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic set_zone(input int z, input logic [2:0] f, input int d);
        req[3*z +: 3]         = f;
        dur[DUR_W*z +: DUR_W] = DUR_W'(d);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [2:0] pat_tbl [10] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010,
                                     3'b001, 3'b000, 3'b110, 3'b011, 3'b111};
        int alarm_left;
        rst_n = 1'b0; tick = 1'b0; alarm = 1'b0; ddm = 4'd0; udm = 4'd0;
        req = '0; dur = '0;
        model_reset();
        idle_cycles(2);
        expect_out("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc_expect("post_reset", 0, 0, 0, 0);

        // Zone 0 drip, dur 3
        set_zone(0, 3'b010, 3);
        cyc_expect("t1_select", 0, 0, 0, 0);
        cyc_expect("t1_run", 2, 0, 1, 0);
        pulse_tick(); expect_out("t1_tick1", 2, 0, 1, 0);
        pulse_tick(); expect_out("t1_tick2", 2, 0, 1, 0);
        pulse_tick(); expect_out("t1_done", 0, 0, 0, 1);
        cyc_expect("t1_gap", 0, 0, 0, 0);
        cyc_expect("t1_again", 2, 0, 1, 0);
        set_zone(0, 3'b000, 0);
        cyc_expect("t1_withdraw", 0, 0, 0, 0);
        idle_cycles(3);

        // Zones 1 and 3 sprinkler, dur 2: order 1,3,1
        set_zone(1, 3'b100, 2);
        set_zone(3, 3'b100, 2);
        cyc_expect("t2_select", 0, 0, 0, 0);
        cyc_expect("t2_z1", 1, 1, 1, 0);
        pulse_tick(); expect_out("t2_z1_t1", 1, 1, 1, 0);
        pulse_tick(); expect_out("t2_z1_done", 0, 1, 0, 1);
        cyc_expect("t2_gap", 0, 1, 0, 0);
        cyc_expect("t2_z3", 1, 3, 1, 0);
        pulse_tick();
        pulse_tick(); expect_out("t2_z3_done", 0, 3, 0, 1);
        idle_cycles(1);
        cyc_expect("t2_z1b", 1, 1, 1, 0);
        set_zone(1, 3'b000, 0);
        set_zone(3, 3'b000, 0);
        cyc_expect("t2_withdraw", 0, 1, 0, 0);
        idle_cycles(3);

        // Zone 2 hybrid, minute 29 -> 30
        ddm = 4'd2; udm = 4'd9;
        set_zone(2, 3'b001, 4);
        cyc_expect("t3_select", 0, 1, 0, 0);
        cyc_expect("t3_run", 1, 2, 1, 0);
        pulse_tick(); expect_out("t3_tick1", 1, 2, 1, 0);
        ddm = 4'd3; udm = 4'd0;
        check("t3_before_edge", int'(coded_irg), 1);
        cyc_expect("t3_switched", 2, 2, 1, 0);
        pulse_tick(); expect_out("t3_tick2", 2, 2, 1, 0);
        pulse_tick(); expect_out("t3_tick3", 2, 2, 1, 0);
        pulse_tick(); expect_out("t3_done", 0, 2, 0, 1);

        // Alarm for 5 cycles with 2 of 4 ticks left, tick coincident
        cyc_expect("t4_select", 0, 2, 0, 0);
        cyc_expect("t4_run", 2, 2, 1, 0);
        pulse_tick(); pulse_tick();
        expect_out("t4_two_left", 2, 2, 1, 0);
        alarm = 1'b1; tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        expect_out("t4_hold", 0, 2, 1, 0);
        for (int i = 0; i < 4; i++) cyc_expect("t4_hold_n", 0, 2, 1, 0);
        alarm = 1'b0;
        cyc_expect("t4_resume", 2, 2, 1, 0);
        pulse_tick(); expect_out("t4_one_left", 2, 2, 1, 0);
        pulse_tick(); expect_out("t4_done", 0, 2, 0, 1);
        set_zone(2, 3'b000, 0);
        idle_cycles(3);

        // Multi-hot and zero-duration requests are ignored
        set_zone(0, 3'b110, 5);
        set_zone(1, 3'b001, 0);
        for (int i = 0; i < 6; i++) cyc_expect("t5_idle", 0, 2, 0, 0);

        // Asynchronous reset mid-run, then zone 0 first
        set_zone(0, 3'b100, 5);
        set_zone(1, 3'b000, 0);
        set_zone(3, 3'b010, 5);
        cyc_expect("t6_select", 0, 2, 0, 0);
        cyc_expect("t6_z3", 2, 3, 1, 0);
        pulse_tick(); expect_out("t6_tick", 2, 3, 1, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        expect_out("t6_async_rst", 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        cyc_expect("t6_select2", 0, 0, 0, 0);
        cyc_expect("t6_z0_first", 1, 0, 1, 0);

        // Randomized phase
        alarm_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst_n = 1'b1;
            tick  = ($urandom_range(3) == 0);
            if (alarm_left > 0) begin alarm = 1'b1; alarm_left--; end
            else if ($urandom_range(60) == 0) begin alarm = 1'b1; alarm_left = $urandom_range(5); end
            else alarm = 1'b0;
            if ($urandom_range(15) == 0) begin
                ddm = ($urandom_range(19) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(5));
                udm = ($urandom_range(19) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(9));
            end
            for (int z = 0; z < ZONES; z++)
                if ($urandom_range(40) == 0) set_zone(z, pat_tbl[$urandom_range(9)], $urandom_range(6));
            if ($urandom_range(700) == 0) rst_n = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
